// File: rtl/sm_clk_en_gen_pkg.sv
// ---------------------------------------------------------------------------
// sm_clk_en_gen_pkg
// Shared definitions for the CPU clock-enable generator.
// Holds the run/step/halt mode encodings and a small helper that classifies a
// mode word. There are no ports. Other files pull this in with
// import sm_clk_en_gen_pkg::*.
// ---------------------------------------------------------------------------
package sm_clk_en_gen_pkg;

   // Mode word as driven by the board switches. Both 00 and 11 mean free-run,
   // so that a switch stuck at either extreme still lets the core run.
   typedef enum logic [1:0] {
      MODE_RUN  = 2'b00,
      MODE_STEP = 2'b01,
      MODE_HALT = 2'b10,
      MODE_RUN2 = 2'b11
   } mode_e;

   // True for either of the two free-run encodings.
   function automatic logic is_run_mode(input logic [1:0] m);
      return (m == MODE_RUN) || (m == MODE_RUN2);
   endfunction

endpackage

// File: rtl/sm_sync_debounce.sv
// ---------------------------------------------------------------------------
// sm_sync_debounce
// Two-flop synchroniser followed by a counting debouncer, for any board push
// button.
//
// Ports:
//   clk   - board clock
//   rst   - asynchronous active-high reset, clears every flop
//   raw   - raw, asynchronous, bouncing button level
//   level - debounced (filtered) level
//   rise  - registered one-cycle pulse, one cycle after level goes 0 -> 1
//
// Parameters:
//   DEB_LEN - consecutive differing samples needed to flip level (>= 1)
//   DEB_W   - counter width, 2**DEB_W must exceed DEB_LEN
// ---------------------------------------------------------------------------
module sm_sync_debounce #(
   parameter int DEB_LEN = 1000,
   parameter int DEB_W   = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_LEN - 1);

   logic             sync1;
   logic             sync2;
   logic             prev;
   logic [DEB_W-1:0] cnt;

   // The first two flops only move the raw button into the clock domain;
   // nothing else looks at sync1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // The counter measures how long the synchronised level has disagreed with
   // the filtered level. A single agreeing sample restarts the measurement.
   // The level flips on the DEB_LEN-th consecutive disagreeing sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync2 != level) begin
         if (cnt == CNT_LAST) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         cnt <= '0;
      end
   end

   // Edge detector. The rise pulse is registered so that users see a clean
   // flop output. It appears one cycle after level goes high and lasts one
   // cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev <= 1'b0;
         rise <= 1'b0;
      end else begin
         prev <= level;
         rise <= level & ~prev;
      end
   end

endmodule

// File: rtl/sm_clk_en_gen.sv
// ---------------------------------------------------------------------------
// sm_clk_en_gen
// Clock-enable generator for the schoolRISCV core. The core runs on the board
// clock and advances only in cycles where clkEn is high.
//
// Ports:
//   clk       - board clock, the only clock
//   rst       - asynchronous active-high reset
//   enable    - global gate; low means no pulses and the divider holds
//   mode      - 00/11 run, 01 single-step, 10 halt
//   divide    - run-mode period minus one
//   stepBtn   - raw bouncing step push-button, active-high
//   clkEn     - registered one-cycle enable pulse
//   running   - registered: high in run mode while enabled
//   tickCount - number of clkEn pulses since reset, wrapping
//
// Parameters:
//   DIV_W, DEB_LEN, DEB_W, CNT_W - widths and debounce length
//   BYPASS - nonzero ties clkEn high in run mode; the divider is then unused
// ---------------------------------------------------------------------------
module sm_clk_en_gen
   import sm_clk_en_gen_pkg::*;
#(
   parameter int DIV_W   = 16,
   parameter int DEB_LEN = 1000,
   parameter int DEB_W   = 10,
   parameter int CNT_W   = 32,
   parameter int BYPASS  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] divide,
   input  logic             stepBtn,
   output logic             clkEn,
   output logic             running,
   output logic [CNT_W-1:0] tickCount
);

   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] div_next;
   logic [1:0]       mode_prev;
   logic             mode_change;
   logic             clk_en_next;
   logic             running_next;
   logic             step_rise;
   // The filtered level is kept for a future debug LED and is not needed here.
   logic             step_level_unused;
   mode_e            cur_mode;

   sm_sync_debounce #(
      .DEB_LEN (DEB_LEN),
      .DEB_W   (DEB_W)
   ) u_step_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (stepBtn),
      .level (step_level_unused),
      .rise  (step_rise)
   );

   assign cur_mode    = mode_e'(mode);
   assign mode_change = (mode != mode_prev);

   // Next-state logic for the divider and the pulse.
   // A mode switch restarts the period from zero. It also swallows any pulse
   // on that edge, including a step edge that happens to arrive at the same
   // time. Otherwise, enable low freezes everything. Run mode uses a >=
   // compare, so shrinking divide mid-period fires at once instead of
   // waiting for div to wrap.
   always_comb begin
      div_next     = div;
      clk_en_next  = 1'b0;
      running_next = enable & is_run_mode(mode);
      if (mode_change) begin
         div_next = '0;
      end else if (enable) begin
         case (cur_mode)
            MODE_RUN, MODE_RUN2: begin
               if (BYPASS != 0) begin
                  clk_en_next = 1'b1;
               end else if (div >= divide) begin
                  clk_en_next = 1'b1;
                  div_next    = '0;
               end else begin
                  div_next = div + 1'b1;
               end
            end
            MODE_STEP: begin
               clk_en_next = step_rise;
            end
            MODE_HALT: begin
               clk_en_next = 1'b0;
            end
            default: begin
               clk_en_next = 1'b0;
            end
         endcase
      end
   end

   // State register. tickCount adds the pulse of the previous cycle, so it
   // trails clkEn by one clock and wraps naturally at its width.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clkEn     <= 1'b0;
         running   <= 1'b0;
         tickCount <= '0;
         div       <= '0;
         mode_prev <= MODE_RUN;
      end else begin
         clkEn     <= clk_en_next;
         running   <= running_next;
         tickCount <= tickCount + CNT_W'(clkEn);
         div       <= div_next;
         mode_prev <= mode;
      end
   end

endmodule
